// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters. A granted command is
// registered onto the ALU inputs, the ALU gets one cycle to settle, and its
// results are captured and returned on a tagged valid/ready response channel.
module alu_arbiter #(
    parameter bit RR    = 1'b1,  // 1 = round-robin, 0 = port 0 always wins
    parameter int CNT_W = 16     // width of the completed-operation counter
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [21:0]      req_ctrl,
    input  logic [255:0]     req_opnd,
    output logic [2:0]       alu_op,
    output logic             alu_form,
    output logic [1:0]       alu_vec,
    output logic [3:0]       alu_logic_select,
    output logic             alu_shift_add,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_c,
    output logic [31:0]      alu_d,
    input  logic [31:0]      alu_y1,
    input  logic [31:0]      alu_y2,
    input  logic [7:0]       alu_cmp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_y1,
    output logic [31:0]      rsp_y2,
    output logic [7:0]       rsp_cmp,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;      // port granted most recently
    logic             id_q;        // port owning the command in flight
    logic [10:0]      alu_ctrl_q;  // {op, form, vec, logic_select, shift_add}
    logic [127:0]     alu_opnd_q;  // {A, B, C, D}
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [31:0]      rsp_y1_q;
    logic [31:0]      rsp_y2_q;
    logic [7:0]       rsp_cmp_q;
    logic [CNT_W-1:0] ops_done_q;
    logic [CNT_W-1:0] ops_done_d;

    logic             accept_ok;
    logic             grant;
    logic             accept;
    logic [10:0]      sel_ctrl;
    logic [127:0]     sel_opnd;

    // Pick a port, drive the one-hot ready and select the granted command.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        grant     = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = RR ? ~last_q : 1'b0;
            default: grant = 1'b0;
        endcase
        accept_ok = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        accept    = accept_ok && req_valid[grant];
        if (accept) req_ready[grant] = 1'b1;
        sel_ctrl   = grant ? req_ctrl[21:11]   : req_ctrl[10:0];
        sel_opnd   = grant ? req_opnd[255:128] : req_opnd[127:0];
        ops_done_d = ops_done_q + CNT_W'(1);
    end

    // Sequencer: accept -> EXEC (ALU settles) -> RESP (hold until taken).
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_opnd_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y1_q    <= '0;
            rsp_y2_q    <= '0;
            rsp_cmp_q   <= '0;
            ops_done_q  <= '0;
        end else begin
            if (accept) begin
                alu_ctrl_q <= sel_ctrl;
                alu_opnd_q <= sel_opnd;
                id_q       <= grant;
                last_q     <= grant;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= EXEC;
                end
                EXEC: begin
                    rsp_y1_q    <= alu_y1;
                    rsp_y2_q    <= alu_y2;
                    rsp_cmp_q   <= alu_cmp;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ops_done_q  <= ops_done_d;
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? EXEC : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {alu_op, alu_form, alu_vec, alu_logic_select, alu_shift_add} = alu_ctrl_q;
    assign {alu_a, alu_b, alu_c, alu_d} = alu_opnd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y1    = rsp_y1_q;
    assign rsp_y2    = rsp_y2_q;
    assign rsp_cmp   = rsp_cmp_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two instances share stimulus -- r_* is round-robin with a
// 4-bit counter, f_* is fixed priority with the default 16-bit counter. Each
// has its own stub ALU computing y1 = A op C, y2 = B op D.
module tb_alu_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [21:0]  req_ctrl = '0;
    logic [255:0] req_opnd = '0;
    logic         rsp_ready = 1'b1;

    logic [1:0]  r_ready, f_ready;
    logic [2:0]  r_op, f_op;
    logic        r_form, f_form, r_sa, f_sa;
    logic [1:0]  r_vec, f_vec;
    logic [3:0]  r_ls, f_ls;
    logic [31:0] r_a, r_b, r_c, r_d, f_a, f_b, f_c, f_d;
    logic [31:0] r_y1, r_y2, f_y1, f_y2;
    logic [7:0]  r_cmp, f_cmp;
    logic        r_rv, f_rv, r_id, f_id;
    logic [31:0] r_ry1, r_ry2, f_ry1, f_ry2;
    logic [7:0]  r_rcmp, f_rcmp;
    logic [3:0]  r_ops;
    logic [15:0] f_ops;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'b000:  return x + y;
            3'b001:  return x - y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            3'b100:  return x ^ y;
            default: return x;
        endcase
    endfunction

    assign r_y1  = alu_f(r_op, r_a, r_c);
    assign r_y2  = alu_f(r_op, r_b, r_d);
    assign r_cmp = {6'b0, r_a == r_c, r_a < r_c};
    assign f_y1  = alu_f(f_op, f_a, f_c);
    assign f_y2  = alu_f(f_op, f_b, f_d);
    assign f_cmp = {6'b0, f_a == f_c, f_a < f_c};

    alu_arbiter #(.RR(1'b1), .CNT_W(4)) dut_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r_ready),
        .req_ctrl(req_ctrl), .req_opnd(req_opnd),
        .alu_op(r_op), .alu_form(r_form), .alu_vec(r_vec),
        .alu_logic_select(r_ls), .alu_shift_add(r_sa),
        .alu_a(r_a), .alu_b(r_b), .alu_c(r_c), .alu_d(r_d),
        .alu_y1(r_y1), .alu_y2(r_y2), .alu_cmp(r_cmp),
        .rsp_valid(r_rv), .rsp_ready(rsp_ready), .rsp_id(r_id),
        .rsp_y1(r_ry1), .rsp_y2(r_ry2), .rsp_cmp(r_rcmp), .ops_done(r_ops)
    );

    alu_arbiter #(.RR(1'b0), .CNT_W(16)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(f_ready),
        .req_ctrl(req_ctrl), .req_opnd(req_opnd),
        .alu_op(f_op), .alu_form(f_form), .alu_vec(f_vec),
        .alu_logic_select(f_ls), .alu_shift_add(f_sa),
        .alu_a(f_a), .alu_b(f_b), .alu_c(f_c), .alu_d(f_d),
        .alu_y1(f_y1), .alu_y2(f_y2), .alu_cmp(f_cmp),
        .rsp_valid(f_rv), .rsp_ready(rsp_ready), .rsp_id(f_id),
        .rsp_y1(f_ry1), .rsp_y2(f_ry2), .rsp_cmp(f_rcmp), .ops_done(f_ops)
    );

    typedef struct {
        logic         port;
        logic [10:0]  ctrl;
        logic [127:0] opnd;
        logic [31:0]  y1;
        logic [31:0]  y2;
        logic [7:0]   cmp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_cmd(input logic port, input logic [10:0] ctrl, input logic [127:0] opnd);
        if (port) begin
            req_ctrl[21:11]   = ctrl;
            req_opnd[255:128] = opnd;
        end else begin
            req_ctrl[10:0]    = ctrl;
            req_opnd[127:0]   = opnd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_ops;
        logic       prev_g;

        // op=ADD form=0 vec=10: A=5 B=7 C=3 D=1 -> y1=8 y2=8
        vecs[0] = '{1'b0, 11'h040, {32'd5, 32'd7, 32'd3, 32'd1}, 32'd8, 32'd8, 8'h00};
        // SUB from port 1: 3-9, 20-5, A<C
        vecs[1] = '{1'b1, 11'h100, {32'd3, 32'd20, 32'd9, 32'd5}, 32'hFFFF_FFFA, 32'd15, 8'h01};
        // XOR, form=1, logic_select=0110, shift_add=1
        vecs[2] = '{1'b0, 11'h48D, {32'hFF00_FF00, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1234_5678},
                    32'hF00F_F00F, 32'h0, 8'h00};
        // OR, vec=01, from port 1, A==C
        vecs[3] = '{1'b1, 11'h320, {32'hA, 32'h50, 32'hA, 32'h0F}, 32'hA, 32'h5F, 8'h02};

        // ---- reset state ----
        do_reset();
        check("reset_rsp_valid", r_rv, 1'b0);
        check("reset_rsp_id", r_id, 1'b0);
        check("reset_alu_ctrl", {r_op, r_form, r_vec, r_ls, r_sa}, 11'h0);
        check("reset_alu_opnd", {r_a, r_b, r_c, r_d}, 128'h0);
        check("reset_rsp_data", {r_ry1, r_ry2, r_rcmp}, 72'h0);
        check("reset_ops_done", r_ops, 4'd0);
        check("reset_req_ready_idle", r_ready, 2'b00);

        // ---- table: single commands, rsp_ready held high ----
        exp_ops = 4'd0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(vecs[i].port, vecs[i].ctrl, vecs[i].opnd);
            req_valid = vecs[i].port ? 2'b10 : 2'b01;
            #1;
            check("tbl_req_ready", r_ready, vecs[i].port ? 2'b10 : 2'b01);
            tick();
            req_valid = 2'b00;
            check("tbl_exec_rsp_valid", r_rv, 1'b0);
            check("tbl_alu_ctrl", {r_op, r_form, r_vec, r_ls, r_sa}, vecs[i].ctrl);
            check("tbl_alu_opnd", {r_a, r_b, r_c, r_d}, vecs[i].opnd);
            tick();
            check("tbl_rsp_valid", r_rv, 1'b1);
            check("tbl_rsp_id", r_id, vecs[i].port);
            check("tbl_rsp_y1", r_ry1, vecs[i].y1);
            check("tbl_rsp_y2", r_ry2, vecs[i].y2);
            check("tbl_rsp_cmp", r_rcmp, vecs[i].cmp);
            check("tbl_fp_rsp_y1", f_ry1, vecs[i].y1);
            tick();
            exp_ops = exp_ops + 4'd1;
            check("tbl_rsp_valid_after", r_rv, 1'b0);
            check("tbl_ops_done", r_ops, exp_ops);
        end

        // ---- contention: both ports valid, RR alternates, FP always port 0 ----
        do_reset();
        set_cmd(1'b0, 11'h100, {32'd10, 32'd50, 32'd4, 32'd8});             // SUB -> 6, 42
        set_cmd(1'b1, 11'h200, {32'hF0F0, 32'h00FF, 32'hFF00, 32'h0F0F});   // AND -> F000, 000F
        req_valid = 2'b11;
        prev_g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", r_ready, k[0] ? 2'b10 : 2'b01);
            check("fp_grant", f_ready, 2'b01);
            if (k > 0) begin
                check("rr_rsp_valid", r_rv, 1'b1);
                check("rr_rsp_id", r_id, prev_g);
                check("rr_rsp_y1", r_ry1, prev_g ? 32'hF000 : 32'd6);
                check("fp_rsp_id", f_id, 1'b0);
                check("fp_rsp_y1", f_ry1, 32'd6);
                check("fp_rsp_y2", f_ry2, 32'd42);
            end
            prev_g = k[0];
            tick();
            check("rr_exec_no_ready", r_ready, 2'b00);
            check("fp_exec_no_ready", f_ready, 2'b00);
            tick();
        end
        // Port 0 drops: fixed priority now serves port 1.
        req_valid = 2'b10;
        #1;
        check("fp_port1_ready", f_ready, 2'b10);
        check("rr_last_rsp_id", r_id, 1'b1);
        check("rr_last_rsp_y2", r_ry2, 32'h000F);
        tick();
        req_valid = 2'b00;
        tick();
        check("fp_port1_rsp_valid", f_rv, 1'b1);
        check("fp_port1_rsp_id", f_id, 1'b1);
        check("fp_port1_rsp_y1", f_ry1, 32'hF000);
        tick();

        // ---- backpressure ----
        do_reset();
        rsp_ready = 1'b0;
        set_cmd(1'b0, 11'h040, {32'd1, 32'd2, 32'd3, 32'd4});               // ADD -> 4, 6
        req_valid = 2'b01;
        tick();
        set_cmd(1'b0, 11'h400, {32'hFF, 32'h0, 32'h0F, 32'h0});             // XOR -> F0, 0
        tick();
        for (int j = 0; j < 5; j++) begin
            check("bp_rsp_valid", r_rv, 1'b1);
            check("bp_rsp_y1", r_ry1, 32'd4);
            check("bp_rsp_y2", r_ry2, 32'd6);
            check("bp_no_ready", r_ready, 2'b00);
            check("bp_alu_op_held", r_op, 3'b000);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", r_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("bp_next_exec_valid", r_rv, 1'b0);
        check("bp_next_alu_op", r_op, 3'b100);
        check("bp_ops_done", r_ops, 4'd1);
        tick();
        check("bp_next_rsp_valid", r_rv, 1'b1);
        check("bp_next_rsp_y1", r_ry1, 32'hF0);
        tick();
        check("bp_ops_done2", r_ops, 4'd2);

        // ---- reset in EXEC: command discarded ----
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("rm_in_exec_op", r_op, 3'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_rsp_valid", r_rv, 1'b0);
        check("rm_alu_op", r_op, 3'b000);
        check("rm_ops_done", r_ops, 4'd0);
        check("rm_fp_ops_done", f_ops, 16'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rm_no_response", r_rv, 1'b0);
        end

        // ---- counter wrap with CNT_W=4: 17 ops ----
        do_reset();
        rsp_ready = 1'b1;
        set_cmd(1'b0, 11'h040, {32'd1, 32'd1, 32'd1, 32'd1});
        req_valid = 2'b01;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 15) check("wrap_ops_15", r_ops, 4'd15);
            if (i == 16) check("wrap_ops_16", r_ops, 4'd0);
            tick();
        end
        req_valid = 2'b00;
        check("wrap_last_rsp_valid", r_rv, 1'b1);
        tick();
        check("wrap_ops_17", r_ops, 4'd1);
        check("wrap_fp_ops_17", f_ops, 16'd17);
        check("wrap_idle", r_rv, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single ALU between two requesters, for example the issue stage (port 0) and the address/branch unit (port 1).
Each requester presents a complete ALU command plus operands over a valid/ready handshake. The block grants one command, registers it onto the ALU inputs and captures Y1/Y2/compare_res. It returns the result over a tagged valid/ready response channel.
It holds no datapath logic of its own. It only sequences, arbitrates and buffers.

Parameters:
RR, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  2  bit i = requester i has a command
req_ready  output  2  bit i = command i accepted this cycle (when valid)
req_ctrl  input  22  per port [11i+10:11i] = {op[2:0], form, vec[1:0], logic_select[3:0], shift_add}
req_opnd  input  256  per port [128i+127:128i] = {A, B, C, D}, A in the MSBs
alu_op  output  3  registered ALU op
alu_form  output  1  registered form
alu_vec  output  2  registered vec
alu_logic_select  output  4  registered logic_select
alu_shift_add  output  1  registered shift_add
alu_a, alu_b, alu_c, alu_d  output  32 each  registered operands
alu_y1, alu_y2  input  32 each  ALU results
alu_cmp  input  8  ALU compare_res
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that issued the result
rsp_y1, rsp_y2  output  32 each  captured results
rsp_cmp  output  8  captured compare result
ops_done  output  CNT_W  completed responses, wrapping

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Reset clears everything:
  - state = IDLE
  - all alu_* outputs = 0 (op ADD)
  - rsp_valid = 0, rsp_id = 0, rsp_y1 = rsp_y2 = rsp_cmp = 0
  - ops_done = 0
  - rr pointer last = 1, so port 0 is favoured first
- Reset mid-operation discards the in-flight command and any pending response. No response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- accept_ok = (state==IDLE) | (state==RESP & rsp_ready).
- Grant g:
  - Only one port valid: g = that port.
  - Both valid with RR=1: g = ~last.
  - Both valid with RR=0: g = 0.
- req_ready[g] = accept_ok & req_valid[g]. The other bit is 0. req_ready is combinational and never high for both ports.
- On acceptance (valid & ready):
  - Load req_ctrl/req_opnd slice g into the alu_* registers.
  - Set the id register to g and last to g.
  - Next state = EXEC.
- EXEC (exactly one cycle, the ALU settles):
  - Capture alu_y1, alu_y2, alu_cmp into rsp_y1, rsp_y2, rsp_cmp.
  - rsp_id <= id, rsp_valid <= 1, next state = RESP.
- RESP: rsp_* hold stable while rsp_valid & ~rsp_ready.
- On the response handshake:
  - ops_done increments, wrapping modulo 2^CNT_W.
  - If a new request is accepted the same cycle: next state = EXEC and rsp_valid <= 0.
  - Otherwise: next state = IDLE and rsp_valid <= 0.
- Latency: acceptance at cycle T gives rsp_valid at T+2.
- Throughput: 1 op per 2 cycles when rsp_ready is held at 1.
- alu_* registers keep the last accepted command in IDLE and RESP. They change only on acceptance.
- A requester may drop req_valid before it is granted. Commands are not queued internally.
- rsp_ready is ignored when rsp_valid = 0.

Test Plan:
- Reset then single ADD: port 0 sends op=000, form=0, vec=10, A=5, B=7, C=3, D=1, rsp_ready=1 -> req_ready[0] high in cycle 0; 2 cycles later rsp_valid=1, rsp_id=0, rsp_y1=8, rsp_y2=8; ops_done=1.
- Round-robin contention: both ports valid continuously (port 0 SUB A=10, C=4; port 1 AND op=010), RR=1, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id alternates; a SUB response has rsp_y1=6.
- Fixed priority: same stimulus with RR=0 -> port 1 is never granted while port 0 stays valid; port 1 is served only once req_valid[0] drops.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_* stable and req_ready=2'b00 throughout; rsp_ready=1 accepts the next pending command in that same cycle.
- Reset mid-operation: assert rst in EXEC -> next cycle rsp_valid=0, alu_op=0, ops_done=0, and no response appears afterwards.
- Counter wrap: CNT_W=4, complete 17 ops -> ops_done reads 1.
